wb_route_fifo: RTL and testbench
================================

Name: wb_route_fifo

Overview:
- Parametrised writeback router: one result stream in, NUM_CH buffered destination channels out (ch0 = integer RF, ch1 = FP RF by default).
- Successor to the single-cycle int/FP writeback demux; adds per-channel FIFOs, valid/ready handshakes, x0 write suppression and a bad-channel flag.
- Sits between the execute/memory result bus and the register-file write ports.

Parameters:
- WIDTH, 32, data width of each result
- RD_W, 5, destination register index width
- NUM_CH, 2, number of destination channels (>=2)
- DEPTH, 4, entries per channel FIFO; power of 2, >=2
- ZERO_DROP_CH, 0, channel whose rd==0 writes are accepted and discarded (hardwired-zero register)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  result present
- in_ready  output  1  router accepts result this cycle
- in_ch  input  $clog2(NUM_CH)  destination channel
- in_rd  input  RD_W  destination register index
- in_data  input  WIDTH  result value
- out_valid  output  NUM_CH  per-channel head entry valid
- out_ready  input  NUM_CH  per-channel consumer ready
- out_rd  output  NUM_CH*RD_W  per-channel head rd, channel c at [c*RD_W +: RD_W]
- out_data  output  NUM_CH*WIDTH  per-channel head data, channel c at [c*WIDTH +: WIDTH]
- bad_ch  output  1  sticky: a result addressed to a channel index >= NUM_CH was seen

Behaviour:
- Single clock domain, clk. Reset is synchronous and active-high on rst.
- Reset: all pointers and counts cleared, out_valid=0, out_rd=0, out_data=0, bad_ch=0. in_ready comes from the cleared state, so it reads 1 in the cycle after reset.
- Reset mid-operation discards all buffered entries; no outputs are produced for them.
- Per channel: circular FIFO with rd_ptr/wr_ptr of $clog2(DEPTH) bits (natural wrap) and count of $clog2(DEPTH)+1 bits.
- in_ready:
  - in_ch < NUM_CH: in_ready = !full[in_ch].
  - in_ch >= NUM_CH: in_ready = 1; the result is dropped and bad_ch is set on the next edge.
- Accept = in_valid & in_ready. An accepted result writes {in_rd, in_data} at wr_ptr of the addressed channel. Exception: in_ch==ZERO_DROP_CH with in_rd==0 is accepted and not stored.
- Pop on channel c = out_valid[c] & out_ready[c]; rd_ptr advances.
- Latency: accepted in cycle N, visible on out_valid in cycle N+1. Throughput is 1 per cycle per channel.
- out_valid[c] = (count[c] != 0).
- Empty channel drives out_rd=0 and out_data=0 so the unselected path is zero, as the legacy demux did.
- Simultaneous push and pop on the same channel: count unchanged, both pointers advance. This is legal when not full.
- When full, push is blocked even if a pop occurs in the same cycle. There is no full-pass-through, so in_ready never depends on out_ready.
- Channels are independent; a full channel does not block results bound for another channel.
- in_ready may be low while in_valid is high; the producer holds in_ch/in_rd/in_data stable until accepted.
- bad_ch clears only on rst.

Optional Feature:
- Macro: WB_ROUTE_BYPASS_EN.
- Defined: if the addressed channel is empty and its out_ready is high, an accepted result drives out_valid/out_rd/out_data of that channel combinationally in the same cycle. The result is consumed without being stored, giving 0-cycle latency. In all other cases the result is stored normally.
- Not defined: no combinational in-to-out path; minimum latency is 1 cycle.
- x0 drop applies in both modes; a dropped write is never bypassed.

Decomposition:
- Package wb_route_pkg:
  - CH_INT=0 and CH_FP=1 channel constants.
  - Default WIDTH/RD_W/DEPTH localparams.
  - typedef wb_entry_t, a packed struct {rd, data}.
- Sub-module wb_chan_fifo, instantiated NUM_CH times via generate:
  - Single-channel FIFO with push/pop, full/empty and head outputs.
  - Holds the pointer and count logic.
- Top level wb_route_fifo holds channel decode, x0 drop, bad_ch and the optional bypass.

Test Plan:
- Reset, then push ch1 rd=3 data=0x3F800000 -> out_valid=2'b10 the next cycle, out_rd[ch1]=3, out_data[ch1]=0x3F800000; ch0 outputs stay 0.
- out_ready=0, push 4 results to ch0 (DEPTH=4) -> in_ready=0 for ch0 after the 4th, while a ch1 push in the same state is still accepted. Then drain with out_ready[0]=1 -> data comes out in FIFO order.
- Push ch0 rd=0 data=0xDEAD -> in_ready=1, ch0 stays empty. Push ch1 rd=0 data=0x1 -> stored and output (FP register 0 is real).
- in_ch=2 with NUM_CH=2 -> in_ready=1, nothing stored, bad_ch=1 from the next cycle until rst.
- ch0 holding 2 entries, simultaneous push and pop for 10 cycles across pointer wrap -> count stays 2, output sequence matches push order. Assert rst mid-stream -> out_valid=0 next cycle.
- With WB_ROUTE_BYPASS_EN, ch0 empty, out_ready[0]=1, push rd=7 data=0x55 -> out_valid[0]=1 in the same cycle, ch0 empty afterwards. Without the macro -> output appears 1 cycle later.

Source files
------------

// File: rtl/wb_route_pkg.sv
// Shared constants and types for the writeback router: channel indices,
// default geometry and the {rd, data} entry layout at default widths.
package wb_route_pkg;

    localparam int CH_INT    = 0;
    localparam int CH_FP     = 1;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_RD_W  = 5;
    localparam int DEF_DEPTH = 4;

    typedef struct packed {
        logic [DEF_RD_W-1:0]  rd;
        logic [DEF_WIDTH-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_chan_fifo.sv
// Single destination-channel circular FIFO holding {rd, data} entries.
// Head outputs read zero while empty so an idle channel presents a clean bus.
module wb_chan_fifo
    import wb_route_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int RD_W  = DEF_RD_W,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [RD_W-1:0]  push_rd,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [RD_W-1:0]  head_rd,
    output logic [WIDTH-1:0] head_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = RD_W + WIDTH;

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    // A full FIFO refuses pushes even when popping this cycle.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; validity is governed by count_q alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= {push_rd, push_data};
        end
    end

    assign {head_rd, head_data} = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/wb_route_fifo.sv
// Writeback router: one result stream into NUM_CH buffered register-file channels,
// with x0 write suppression and a sticky bad-channel flag. Optional same-cycle
// bypass into an empty, ready channel when WB_ROUTE_BYPASS_EN is defined.
module wb_route_fifo
    import wb_route_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int RD_W         = DEF_RD_W,
    parameter int NUM_CH       = 2,
    parameter int DEPTH        = DEF_DEPTH,
    parameter int ZERO_DROP_CH = CH_INT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [$clog2(NUM_CH)-1:0] in_ch,
    input  logic [RD_W-1:0]           in_rd,
    input  logic [WIDTH-1:0]          in_data,
    output logic [NUM_CH-1:0]         out_valid,
    input  logic [NUM_CH-1:0]         out_ready,
    output logic [NUM_CH*RD_W-1:0]    out_rd,
    output logic [NUM_CH*WIDTH-1:0]   out_data,
    output logic                      bad_ch
);

    localparam int              CH_W     = $clog2(NUM_CH);
    localparam logic [CH_W:0]   CH_LIMIT = (CH_W+1)'(NUM_CH);

    logic [NUM_CH-1:0] ch_sel, full, empty, push, pop, bypass;
    logic              in_bad, accept, x0_drop, store;
    logic              bad_ch_q, bad_ch_d;
    logic [RD_W-1:0]   head_rd   [NUM_CH];
    logic [WIDTH-1:0]  head_data [NUM_CH];

    always_comb begin
        ch_sel = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            ch_sel[c] = ({1'b0, in_ch} == (CH_W+1)'(c));
        end
    end

    // Out-of-range channels are always taken so a stray result cannot stall the bus.
    assign in_bad   = ({1'b0, in_ch} >= CH_LIMIT);
    assign in_ready = in_bad | (|(ch_sel & ~full));
    assign accept   = in_valid & in_ready;
    assign x0_drop  = ch_sel[ZERO_DROP_CH] & (in_rd == '0);
    assign store    = accept & ~x0_drop;

`ifdef WB_ROUTE_BYPASS_EN
    assign bypass = {NUM_CH{store}} & ch_sel & empty & out_ready;
`else
    assign bypass = '0;
`endif

    assign push = {NUM_CH{store}} & ch_sel & ~bypass;
    assign pop  = out_ready & ~empty;

    assign bad_ch_d = bad_ch_q | (in_valid & in_bad);

    always_ff @(posedge clk) begin
        if (rst) begin
            bad_ch_q <= 1'b0;
        end else begin
            bad_ch_q <= bad_ch_d;
        end
    end

    assign bad_ch = bad_ch_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        wb_chan_fifo #(
            .WIDTH (WIDTH),
            .RD_W  (RD_W),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (push[g]),
            .push_rd   (in_rd),
            .push_data (in_data),
            .pop       (pop[g]),
            .full      (full[g]),
            .empty     (empty[g]),
            .head_rd   (head_rd[g]),
            .head_data (head_data[g])
        );

        assign out_valid[g]                = ~empty[g] | bypass[g];
        assign out_rd[g*RD_W +: RD_W]      = bypass[g] ? in_rd   : head_rd[g];
        assign out_data[g*WIDTH +: WIDTH]  = bypass[g] ? in_data : head_data[g];
    end

endmodule

// File: tb/tb_wb_route_fifo.sv
// Scoreboard bench for wb_route_fifo: the driver queues expected {rd, data} per
// channel on acceptance; a monitor pops and compares on every output handshake.
module tb_wb_route_fifo;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready;
    logic [0:0]  in_ch;
    logic [4:0]  in_rd;
    logic [31:0] in_data;
    logic [1:0]  out_valid, out_ready;
    logic [9:0]  out_rd;
    logic [63:0] out_data;
    logic        bad_ch;

    logic        in3_valid, in3_ready;
    logic [1:0]  in3_ch;
    logic [4:0]  in3_rd;
    logic [31:0] in3_data;
    logic [2:0]  out3_valid, out3_ready;
    logic [14:0] out3_rd;
    logic [95:0] out3_data;
    logic        bad3;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [36:0] q0[$];
    logic [36:0] q1[$];
    logic [36:0] mon_got, mon_exp;
    bit          ok;

    wb_route_fifo u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_ch(in_ch), .in_rd(in_rd), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
        .out_data(out_data), .bad_ch(bad_ch)
    );

    wb_route_fifo #(.NUM_CH(3)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(in3_valid), .in_ready(in3_ready),
        .in_ch(in3_ch), .in_rd(in3_rd), .in_data(in3_data),
        .out_valid(out3_valid), .out_ready(out3_ready), .out_rd(out3_rd),
        .out_data(out3_data), .bad_ch(bad3)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drives one result and waits (bounded) for acceptance; queues the expected
    // output unless the write targets integer x0.
    task automatic send(input int ch, input logic [4:0] rd, input logic [31:0] d, output bit acc);
        acc = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_ch    = ch[0:0];
        in_rd    = rd;
        in_data  = d;
        for (int n = 0; n < 20 && !acc; n++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                if (ch == 0 && rd != 5'd0) q0.push_back({rd, d});
                else if (ch == 1)          q1.push_back({rd, d});
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!acc) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout ch%0d: got no in_ready expected accept", ch);
        end
    endtask

    always @(negedge clk) begin
        #2;
        if (!rst) begin
            for (int c = 0; c < 2; c++) begin
                if (out_valid[c] && out_ready[c]) begin
                    mon_got = {out_rd[c*5 +: 5], out_data[c*32 +: 32]};
                    if ((c == 0 && q0.size() == 0) || (c == 1 && q1.size() == 0)) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL ch%0d_unexpected: got 0x%0h expected no output", c, mon_got);
                    end else begin
                        if (c == 0) mon_exp = q0.pop_front();
                        else        mon_exp = q1.pop_front();
                        check($sformatf("ch%0d_pop", c), 64'(mon_got), 64'(mon_exp));
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_ch = '0; in_rd = '0; in_data = '0; out_ready = '0;
        in3_valid = 1'b0; in3_ch = '0; in3_rd = '0; in3_data = '0; out3_ready = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        @(negedge clk);
        check("rst_out_valid", out_valid, 2'b00);
        check("rst_out_rd", out_rd, 10'h0);
        check("rst_out_data", out_data, 64'h0);
        check("rst_bad_ch", bad_ch, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);

        // single FP result, one-cycle latency
        send(1, 5'd3, 32'h3F800000, ok);
        @(negedge clk);
        check("fp_out_valid", out_valid, 2'b10);
        check("fp_out_rd", out_rd, {5'd3, 5'd0});
        check("fp_out_data", out_data, {32'h3F800000, 32'h0});
        @(posedge clk); #1 out_ready = 2'b10;
        @(posedge clk); #1 out_ready = 2'b00;

        // fill ch0, confirm it blocks while ch1 still accepts, then drain in order
        for (int i = 1; i <= 4; i++) begin
            send(0, 5'(i), 32'h100 + i, ok);
        end
        @(negedge clk);
        check("full_head_rd", out_rd[4:0], 5'd1);
        @(posedge clk); #1;
        in_valid = 1'b1; in_ch = 1'b0; in_rd = 5'd5; in_data = 32'h105;
        @(negedge clk);
        check("ch0_full_in_ready", in_ready, 1'b0);
        @(posedge clk); #1 in_valid = 1'b0;
        send(1, 5'd9, 32'h99, ok);
        check("ch1_accept_while_ch0_full", ok, 1'b1);
        out_ready = 2'b11;
        repeat (6) @(posedge clk);
        #1 out_ready = 2'b00;
        @(negedge clk);
        check("drained_out_valid", out_valid, 2'b00);

        // x0 drop on integer channel, FP register 0 is real
        send(0, 5'd0, 32'hDEAD, ok);
        check("x0_accepted", ok, 1'b1);
        @(negedge clk);
        check("x0_not_stored", out_valid, 2'b00);
        send(1, 5'd0, 32'h1, ok);
        @(negedge clk);
        check("fp0_out_valid", out_valid, 2'b10);
        check("fp0_out_data", out_data, {32'h1, 32'h0});
        @(posedge clk); #1 out_ready = 2'b10;
        @(posedge clk); #1 out_ready = 2'b00;

        // bad channel on a 3-channel instance
        in3_valid = 1'b1; in3_ch = 2'd3; in3_rd = 5'd5; in3_data = 32'h77;
        @(negedge clk);
        check("bad_in_ready", in3_ready, 1'b1);
        check("bad_before_edge", bad3, 1'b0);
        @(posedge clk); #1 in3_valid = 1'b0;
        @(negedge clk);
        check("bad_set", bad3, 1'b1);
        check("bad_nothing_stored", out3_valid, 3'b000);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("bad_sticky", bad3, 1'b1);
        check("main_bad_clear", bad_ch, 1'b0);

        // two entries held while pushing and popping together across pointer wrap
        send(0, 5'd1, 32'h201, ok);
        send(0, 5'd2, 32'h202, ok);
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1; in_ch = 1'b0; in_rd = 5'(k + 3); in_data = 32'h300 + k;
            out_ready = 2'b01;
            @(negedge clk);
            check($sformatf("stream_in_ready%0d", k), in_ready, 1'b1);
            if (in_ready) q0.push_back({in_rd, in_data});
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 2'b00;
        @(negedge clk);
        check("stream_out_valid", out_valid, 2'b01);
        check("stream_head_rd", out_rd[4:0], 5'd11);
        @(posedge clk); #1 rst = 1'b1;
        q0.delete();
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", out_valid, 2'b00);
        check("midrst_out_data", out_data, 64'h0);
        check("midrst_bad3_clear", bad3, 1'b0);

        // latency into an empty, ready channel
        @(posedge clk); #1;
        out_ready = 2'b01;
        in_valid = 1'b1; in_ch = 1'b0; in_rd = 5'd7; in_data = 32'h55;
        @(negedge clk);
        check("lat_in_ready", in_ready, 1'b1);
        if (in_ready) q0.push_back({5'd7, 32'h55});
`ifdef WB_ROUTE_BYPASS_EN
        check("byp_same_cycle_valid", out_valid, 2'b01);
        check("byp_same_cycle_rd", out_rd[4:0], 5'd7);
        check("byp_same_cycle_data", out_data[31:0], 32'h55);
`else
        check("nobyp_same_cycle_valid", out_valid, 2'b00);
`endif
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
`ifdef WB_ROUTE_BYPASS_EN
        check("byp_next_cycle_empty", out_valid, 2'b00);
`else
        check("nobyp_next_cycle_valid", out_valid, 2'b01);
        check("nobyp_next_cycle_data", out_data[31:0], 32'h55);
`endif
        @(posedge clk); #1 out_ready = 2'b00;
        @(negedge clk);
        check("lat_final_empty", out_valid, 2'b00);
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
